// File: rtl/io_filter_pkg.sv
// Shared definitions for io_filter_v2: edge-select encodings, chunk sizing
// and mesh slot numbering for the joined port pairs.
package io_filter_pkg;

    // Per-pin event selection, two bits per pin on edge_mode.
    typedef enum logic [1:0] {
        EDGE_ANY  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    // Number of DATA_WIDTH-wide chunks needed to carry all pins.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Mesh slot of joined output chunk k (data flows mesh -> pins).
    function automatic int slot_out_chunk(input int io_pins, input int k);
        return io_pins + 2 * k;
    endfunction

    // Mesh slot of joined input chunk k (data flows pins -> mesh).
    function automatic int slot_in_chunk(input int io_pins, input int k);
        return io_pins + 2 * k + 1;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-pin input conditioning: SYNC_STAGES-flop synchroniser, debounce
// counter and registered rise/fall pulses. The exported filt is delayed one
// cycle so that it lines up with the rise/fall pulses.
module io_debounce
    import io_filter_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_raw,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   deb;
    logic                   filt_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign filt = filt_q;

    // Synchroniser chain for the asynchronous pad input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pin_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    if (DEBOUNCE_LEN == 0) begin : g_bypass
        assign deb = s;
    end else begin : g_count
        localparam int CW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
        logic [CW-1:0] cnt_q;
        logic          deb_q;

        assign deb = deb_q;

        // Accept a new level only after DEBOUNCE_LEN stable cycles.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (s == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_LEN - 1)) begin
                deb_q <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Edge detect on the debounced level; pulses are one cycle wide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            filt_q <= deb;
            rise   <= deb & ~filt_q;
            fall   <= ~deb & filt_q;
        end
    end

endmodule

// File: rtl/io_filter_v2.sv
// Pin/port bridge between the pad ring and mem_mesh. Slots 0..IO_PINS-1 are
// individual pin ports; each chunk k owns an output slot IO_PINS+2k and an
// input slot IO_PINS+2k+1. Optional build macro IO_FILTER_TOGGLE_EN makes an
// individual write with data bit1=1 toggle the pin instead of writing bit0.
module io_filter_v2
    import io_filter_pkg::*;
#(
    parameter int  IO_PINS      = 16,
    parameter int  DATA_WIDTH   = 16,
    parameter int  SYNC_STAGES  = 2,
    parameter int  DEBOUNCE_LEN = 3,
    localparam int CHUNKS       = ceil_div(IO_PINS, DATA_WIDTH),
    localparam int PORTS        = IO_PINS + 2 * CHUNKS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IO_PINS-1:0]          pin_dir,
    input  logic [2*IO_PINS-1:0]        edge_mode,
    input  logic [IO_PINS-1:0]          pin_data_in,
    output logic [IO_PINS-1:0]          pin_data_out,
    output logic [PORTS-1:0]            port_active_in,
    input  logic [PORTS-1:0]            port_active_out,
    output logic [PORTS*DATA_WIDTH-1:0] port_data_in,
    input  logic [PORTS*DATA_WIDTH-1:0] port_data_out
);

    localparam int JW = CHUNKS * DATA_WIDTH;
    localparam int RW = $clog2(JW);

    logic [IO_PINS-1:0] filt, rise, fall, ind_event, ind_wr_bit0;
    logic [IO_PINS-1:0] saved_out, saved_next;
    logic [JW-1:0]      joined_next, joined_last, joined_out, joined_en_bits;
    logic [PORTS-1:0]   active_next;
    logic [RW-1:0]      irank, orank;
    logic               unused_port_bits;

    // Most data bits of the write slots are don't-care (only bit0/bit1 of
    // individual slots and the output-chunk slices carry meaning).
    assign unused_port_bits = ^{port_data_out, port_active_out};

    for (genvar gi = 0; gi < IO_PINS; gi++) begin : g_pin
        edge_mode_e mode;
        assign mode = edge_mode_e'(edge_mode[2*gi +: 2]);

        io_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_LEN(DEBOUNCE_LEN)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin_raw(pin_data_in[gi]),
            .filt   (filt[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi])
        );

        assign ind_event[gi] = !pin_dir[gi] &&
            ((rise[gi] && (mode == EDGE_ANY || mode == EDGE_RISE)) ||
             (fall[gi] && (mode == EDGE_ANY || mode == EDGE_FALL)));
        assign active_next[gi] = ind_event[gi];
        assign ind_wr_bit0[gi] = port_data_out[gi*DATA_WIDTH];
        assign port_data_in[gi*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{filt[gi]}};
    end

    for (genvar gk = 0; gk < CHUNKS; gk++) begin : g_chunk
        localparam int OS = slot_out_chunk(IO_PINS, gk);
        localparam int IS = slot_in_chunk(IO_PINS, gk);

        assign joined_out[gk*DATA_WIDTH +: DATA_WIDTH]     = port_data_out[OS*DATA_WIDTH +: DATA_WIDTH];
        assign joined_en_bits[gk*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{port_active_out[OS]}};
        assign port_data_in[OS*DATA_WIDTH +: DATA_WIDTH]   = '0;
        assign port_data_in[IS*DATA_WIDTH +: DATA_WIDTH]   = joined_last[gk*DATA_WIDTH +: DATA_WIDTH];
        assign active_next[OS] = 1'b0;
        assign active_next[IS] = |(joined_next[gk*DATA_WIDTH +: DATA_WIDTH] ^
                                   joined_last[gk*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Compress filtered input pins LSB-first into the joined input vector.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        joined_next = '0;
        irank       = '0;
        for (int i = 0; i < IO_PINS; i++) begin
            if (!pin_dir[i]) begin
                joined_next[irank] = filt[i];
                irank = irank + RW'(1);
            end
        end
    end

`ifdef IO_FILTER_TOGGLE_EN
    logic [IO_PINS-1:0] ind_wr_bit1;
    for (genvar gt = 0; gt < IO_PINS; gt++) begin : g_toggle
        assign ind_wr_bit1[gt] = port_data_out[gt*DATA_WIDTH + 1];
    end
`endif

    // Next pad values: joined writes decompressed onto output pins, then
    // individual writes on top so they win for the same pin.
    always_comb begin
        saved_next = saved_out;
        orank      = '0;
        for (int i = 0; i < IO_PINS; i++) begin
            if (pin_dir[i]) begin
                if (joined_en_bits[orank]) begin
                    saved_next[i] = joined_out[orank];
                end
                orank = orank + RW'(1);
            end
            if (port_active_out[i]) begin
`ifdef IO_FILTER_TOGGLE_EN
                if (ind_wr_bit1[i]) begin
                    saved_next[i] = ~saved_out[i];
                end else begin
                    saved_next[i] = ind_wr_bit0[i];
                end
`else
                saved_next[i] = ind_wr_bit0[i];
`endif
            end
        end
    end

    // Registered pad values, joined-input history and event strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            saved_out      <= '0;
            joined_last    <= '0;
            port_active_in <= '0;
        end else begin
            saved_out      <= saved_next;
            joined_last    <= joined_next;
            port_active_in <= active_next;
        end
    end

    assign pin_data_out = saved_out;

endmodule
